// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline (load-use, EX redirect, multi-cycle hold).
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and flush-event performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_wd_addr,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        ex_mc_start,
    input  logic        mc_done,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mc_busy,
    output logic        mc_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    typedef enum logic {RUN, MC_WAIT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MC_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load_use;
    logic             mc_hold;

    always_comb begin
        load_use = ex_is_load && (ex_wd_addr != 5'd0) &&
                   ((id_uses_rs && (id_rs_addr == ex_wd_addr)) ||
                    (id_uses_rt && (id_rt_addr == ex_wd_addr)));
        mc_hold  = (state == MC_WAIT) && !mc_done;
    end

    // Priority: reset, multi-cycle hold, EX redirect, load-use.
    always_comb begin
        stall          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (rst) begin
            flush = '1;
        end else if (mc_hold) begin
            stall = 5'b01111;
            flush = 5'b10000;
        end else if (ex_branch_taken) begin
            flush          = 5'b00110;
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_target;
        end else if (load_use) begin
            stall = 5'b00011;
            flush = 5'b00100;
        end
        mc_busy = !rst && (state == MC_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            count  <= '0;
            mc_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mc_start) begin
                        state <= MC_WAIT;
                        count <= '0;
                    end
                end
                MC_WAIT: begin
                    if (count < TIMEOUT)
                        count <= count + 1'b1;
                    // Flag lands on the same edge the counter reaches the limit.
                    if (count >= TIMEOUT - 1'b1)
                        mc_err <= 1'b1;
                    if (mc_done)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic branch_cyc;

    always_comb branch_cyc = !rst && !mc_hold && ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (|stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (branch_cyc)
                perf_flush_events <= perf_flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a negedge monitor checks.
// Build with HAZARD_PERF_CNT_EN to also exercise the performance counters.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_wd_addr;
    logic        id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken, ex_mc_start, mc_done;
    logic [31:0] ex_branch_target;
    logic [4:0]  stall, flush;
    logic        redirect_valid, mc_busy, mc_err;
    logic [31:0] redirect_pc;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_wd_addr(ex_wd_addr),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mc_busy(mc_busy), .mc_err(mc_err)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        rv;
        logic [31:0] pc;
        logic        busy;
        logic        err;
        logic        chk_perf;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    function automatic exp_t mk(input string n, input logic [4:0] s, input logic [4:0] f,
                                input logic rv, input logic [31:0] pc,
                                input logic busy, input logic err);
        exp_t e;
        e.name = n; e.stall = s; e.flush = f; e.rv = rv; e.pc = pc;
        e.busy = busy; e.err = err; e.chk_perf = 1'b0; e.ps = '0; e.pf = '0;
        return e;
    endfunction

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            bad = (stall !== e.stall) || (flush !== e.flush) || (redirect_valid !== e.rv) ||
                  (redirect_pc !== e.pc) || (mc_busy !== e.busy) || (mc_err !== e.err);
`ifdef HAZARD_PERF_CNT_EN
            if (e.chk_perf)
                bad = bad || (perf_stall_cycles !== e.ps) || (perf_flush_events !== e.pf);
            if (bad && e.chk_perf)
                $display("FAIL %s: perf got ps=%0d pf=%0d want ps=%0d pf=%0d", e.name,
                         perf_stall_cycles, perf_flush_events, e.ps, e.pf);
`endif
            compared++;
            if (bad) begin
                mismatched++;
                $display("FAIL %s: got stall=%b flush=%b rv=%b pc=%h busy=%b err=%b want stall=%b flush=%b rv=%b pc=%h busy=%b err=%b",
                         e.name, stall, flush, redirect_valid, redirect_pc, mc_busy, mc_err,
                         e.stall, e.flush, e.rv, e.pc, e.busy, e.err);
            end
        end
    end

    task automatic idle_inputs();
        id_rs_addr = '0; id_rt_addr = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_is_load = 0; ex_wd_addr = '0; ex_branch_taken = 0; ex_branch_target = '0;
        ex_mc_start = 0; mc_done = 0;
    endtask

    task automatic rand_inputs();
        id_rs_addr = 5'($urandom); id_rt_addr = 5'($urandom);
        id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
        ex_is_load = 1'($urandom); ex_wd_addr = 5'($urandom);
        ex_branch_taken = 1'($urandom); ex_branch_target = $urandom;
        ex_mc_start = 1'($urandom); mc_done = 1'($urandom);
    endtask

    task automatic load_use_rt8();
        idle_inputs();
        ex_is_load = 1; ex_wd_addr = 5'd8; id_uses_rt = 1; id_rt_addr = 5'd8;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst = 1;
        rand_inputs();
        @(posedge clk); #1;   // mc_err is undefined before the first edge

        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step(mk("reset", 5'b00000, 5'b11111, 0, 32'h0, 0, 0));
        end

        rst = 0;
        idle_inputs();
        step(mk("idle", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

        load_use_rt8();
        step(mk("load_use_rt", 5'b00011, 5'b00100, 0, 32'h0, 0, 0));

        idle_inputs();
        ex_is_load = 1; ex_wd_addr = 5'd8; id_uses_rs = 1; id_rs_addr = 5'd8;
        step(mk("load_use_rs", 5'b00011, 5'b00100, 0, 32'h0, 0, 0));

        idle_inputs();
        ex_is_load = 1; ex_wd_addr = 5'd0; id_uses_rt = 1; id_rt_addr = 5'd0;
        step(mk("load_r0", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

        load_use_rt8(); id_rt_addr = 5'd9;
        step(mk("load_nomatch", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

        load_use_rt8(); id_uses_rt = 0;
        step(mk("load_unused_rt", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

        load_use_rt8(); ex_branch_taken = 1; ex_branch_target = 32'h0040_0020;
        step(mk("branch_over_hazard", 5'b00000, 5'b00110, 1, 32'h0040_0020, 0, 0));

        idle_inputs(); ex_mc_start = 1;
        step(mk("mc_start", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i == 4) begin
                load_use_rt8(); ex_branch_taken = 1; ex_branch_target = 32'h1234_5678;
                ex_mc_start = 1;
            end
            step(mk("mc_hold", 5'b01111, 5'b10000, 0, 32'h0, 1, 0));
        end
        idle_inputs(); mc_done = 1;
        step(mk("mc_done", 5'b00000, 5'b00000, 0, 32'h0, 1, 0));
        idle_inputs();
        step(mk("mc_after", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

        idle_inputs(); ex_mc_start = 1;
        step(mk("to_start", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));
        for (int j = 1; j <= MC_TIMEOUT + 5; j++) begin
            idle_inputs();
            // count equals j-1 in wait cycle j; the flag shows once count hits the limit
            step(mk("to_wait", 5'b01111, 5'b10000, 0, 32'h0, 1, (j >= MC_TIMEOUT + 1)));
        end
        rst = 1;
        step(mk("to_rst", 5'b00000, 5'b11111, 0, 32'h0, 0, 1));
        rst = 0;
        step(mk("to_after_rst", 5'b00000, 5'b00000, 0, 32'h0, 0, 0));

`ifdef HAZARD_PERF_CNT_EN
        rst = 1; idle_inputs();
        step(mk("perf_rst", 5'b00000, 5'b11111, 0, 32'h0, 0, 0));
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            load_use_rt8();
            step(mk("perf_lu", 5'b00011, 5'b00100, 0, 32'h0, 0, 0));
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs(); ex_branch_taken = 1; ex_branch_target = 32'h0000_0100;
            step(mk("perf_br", 5'b00000, 5'b00110, 1, 32'h0000_0100, 0, 0));
        end
        idle_inputs();
        e = mk("perf_counts", 5'b00000, 5'b00000, 0, 32'h0, 0, 0);
        e.chk_perf = 1'b1; e.ps = 32'd3; e.pf = 32'd2;
        step(e);
`endif

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
